// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI command decoder.
package spi_pkg;

  localparam int ADDR_WIDTH = 17;

  typedef enum logic [1:0] {
    OP_READ_AT    = 2'b00,
    OP_READ_NEXT  = 2'b01,
    OP_WRITE_AT   = 2'b10,
    OP_WRITE_NEXT = 2'b11
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_BUS
  } state_e;

endpackage

// File: rtl/spi_cmd_decoder.sv
// Decodes SPI command byte streams into single bus read/write requests.
// Define SPI_CMD_AUTOINC_EN to enable READ_NEXT/WRITE_NEXT and address auto-increment.
module spi_cmd_decoder
  import spi_pkg::*;
(
  input  logic                  clk_sys_i,
  input  logic                  reset_ni,
  input  logic [7:0]            spi_rx_byte_i,
  input  logic                  spi_rx_valid_i,
  input  logic                  spi_reset_i,
  output logic [7:0]            spi_tx_byte_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [7:0]            data_o,
  output logic                  we_o,
  output logic                  strobe_o,
  input  logic [7:0]            data_i,
  input  logic                  done_i,
  output logic                  overrun_o
);

  state_e                  state_reg, state_next;
  opcode_e                 op_reg, op_next;
  logic                    a16_reg, a16_next;
  logic [7:0]              data_buf_reg, data_buf_next;
  logic [7:0]              addr_hi_reg, addr_hi_next;
  logic [ADDR_WIDTH-1:0]   addr_next;
  logic [7:0]              data_out_next;
  logic                    we_next;
  logic                    strobe_next;
  logic [7:0]              tx_next;
  logic                    overrun_next;

  // Effective state/address after applying same-cycle done and spi_reset.
  state_e                  cur_state;
  logic [ADDR_WIDTH-1:0]   base_addr;
  opcode_e                 cmd_op;

  always_ff @(posedge clk_sys_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_reg     <= ST_IDLE;
      op_reg        <= OP_READ_AT;
      a16_reg       <= 1'b0;
      data_buf_reg  <= 8'h00;
      addr_hi_reg   <= 8'h00;
      addr_o        <= '0;
      data_o        <= 8'h00;
      we_o          <= 1'b0;
      strobe_o      <= 1'b0;
      spi_tx_byte_o <= 8'h00;
      overrun_o     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      op_reg        <= op_next;
      a16_reg       <= a16_next;
      data_buf_reg  <= data_buf_next;
      addr_hi_reg   <= addr_hi_next;
      addr_o        <= addr_next;
      data_o        <= data_out_next;
      we_o          <= we_next;
      strobe_o      <= strobe_next;
      spi_tx_byte_o <= tx_next;
      overrun_o     <= overrun_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    op_next       = op_reg;
    a16_next      = a16_reg;
    data_buf_next = data_buf_reg;
    addr_hi_next  = addr_hi_reg;
    addr_next     = addr_o;
    data_out_next = data_o;
    we_next       = we_o;
    strobe_next   = strobe_o;
    tx_next       = spi_tx_byte_o;
    overrun_next  = overrun_o;
    cur_state     = state_reg;
    base_addr     = addr_o;
    cmd_op        = opcode_e'(spi_rx_byte_i[7:6]);

    // Bus completion is handled first so a byte in the same cycle sees IDLE.
    if (state_reg == ST_BUS && done_i) begin
      strobe_next = 1'b0;
      state_next  = ST_IDLE;
      cur_state   = ST_IDLE;
      if (!we_o) tx_next = data_i;
`ifdef SPI_CMD_AUTOINC_EN
      base_addr   = addr_o + 17'd1;
      addr_next   = base_addr;
`endif
    end

    // A pending bus cycle survives transaction end; partial commands do not.
    if (spi_reset_i) begin
      overrun_next = 1'b0;
      if (cur_state != ST_BUS) begin
        cur_state  = ST_IDLE;
        state_next = ST_IDLE;
      end
    end

    if (spi_rx_valid_i) begin
      case (cur_state)
        ST_IDLE: begin
          op_next  = cmd_op;
          a16_next = spi_rx_byte_i[0];
          case (cmd_op)
            OP_READ_AT:  state_next = ST_ADDR_HI;
            OP_WRITE_AT: state_next = ST_DATA;
`ifdef SPI_CMD_AUTOINC_EN
            OP_READ_NEXT: begin
              state_next  = ST_BUS;
              strobe_next = 1'b1;
              we_next     = 1'b0;
              addr_next   = base_addr;
            end
            OP_WRITE_NEXT: state_next = ST_DATA;
`else
            OP_READ_NEXT, OP_WRITE_NEXT: begin
              state_next   = ST_IDLE;
              overrun_next = 1'b1;
            end
`endif
          endcase
        end
        ST_DATA: begin
          data_buf_next = spi_rx_byte_i;
          if (op_reg == OP_WRITE_NEXT) begin
            state_next    = ST_BUS;
            strobe_next   = 1'b1;
            we_next       = 1'b1;
            addr_next     = base_addr;
            data_out_next = spi_rx_byte_i;
          end else begin
            state_next = ST_ADDR_HI;
          end
        end
        ST_ADDR_HI: begin
          addr_hi_next = spi_rx_byte_i;
          state_next   = ST_ADDR_LO;
        end
        ST_ADDR_LO: begin
          state_next    = ST_BUS;
          strobe_next   = 1'b1;
          we_next       = (op_reg == OP_WRITE_AT);
          addr_next     = {a16_reg, addr_hi_reg, spi_rx_byte_i};
          data_out_next = data_buf_reg;
        end
        ST_BUS: overrun_next = 1'b1;
        default: state_next = ST_IDLE;
      endcase
    end
  end

endmodule
